fifo_fir_stage: RTL and testbench

//  Downstream consumer of the sample FIFO. Pops one signed sample per FIFO read,

---
 rtl/fifo_fir_stage_if.sv | 51 +++++
 rtl/fifo_fir_stage.sv | 135 +++++++++++++
 tb/tb_fifo_fir_stage.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_fir_stage_if.sv
// ---------------------------------------------------------------------------
// fifo_fir_stage_if
// Bundles the three port groups of the FIR stage: the FIFO read side, the
// coefficient write port and the filtered-sample output port.
//
//   fifo_empty  FIFO has no data
//   fifo_rd_en  one-cycle read strobe towards the FIFO
//   fifo_data   FIFO registered read data, valid the cycle after fifo_rd_en
//   coef_wr     coefficient write strobe
//   coef_addr   tap index of the write
//   coef_data   coefficient value (signed fixed point)
//   out_valid   out_data holds a result
//   out_ready   downstream can take the result
//   out_data    filtered sample (signed)
//   busy        stage is working on a sample
//
// Output handshake: a result transfers on every rising clk edge where
// out_valid and out_ready are both high. Once out_valid rises, out_valid and
// out_data hold steady until that transfer. out_ready may change freely and
// is ignored while out_valid is low.
//
// Modports: master = the FIR stage, slave = the FIFO/downstream environment.
// ---------------------------------------------------------------------------
interface fifo_fir_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int COEF_WIDTH = 16,
   parameter int TAPS       = 4
);
   localparam int ADDR_W = $clog2(TAPS);

   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  coef_wr;
   logic [ADDR_W-1:0]     coef_addr;
   logic [COEF_WIDTH-1:0] coef_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  busy;

   modport master (
      input  fifo_empty, fifo_data, coef_wr, coef_addr, coef_data, out_ready,
      output fifo_rd_en, out_valid, out_data, busy
   );

   modport slave (
      output fifo_empty, fifo_data, coef_wr, coef_addr, coef_data, out_ready,
      input  fifo_rd_en, out_valid, out_data, busy
   );
endinterface

// File: rtl/fifo_fir_stage.sv
// ---------------------------------------------------------------------------
// fifo_fir_stage
// Pops one signed sample per FIFO read, filters it through a TAPS-tap FIR
// using a single multiply-accumulate per cycle, and offers the result on a
// valid/ready port. Coefficients can be rewritten at runtime while idle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   bus        fifo_fir_stage_if.master (FIFO read, coef write, output port)
//   dbg_state  current FSM state encoding (IDLE=0 REQ=1 CAP=2 MAC=3 OUT=4)
//
// Build option: define FIR_ROUND_EN to round half toward +inf before the
// fractional shift; without it the shift floors. Both paths then saturate.
//
// Sequence per sample: IDLE -> REQ (rd strobe) -> CAP (shift in sample)
// -> MAC x TAPS -> OUT (hold until accepted) -> IDLE.
// ---------------------------------------------------------------------------
module fifo_fir_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int COEF_WIDTH = 16,
   parameter int FRAC_BITS  = 14,
   parameter int TAPS       = 4,
   parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_fir_stage_if.master     bus,
   output logic [2:0]           dbg_state
);
   localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
   localparam int TAP_W  = $clog2(TAPS);

   localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1 << FRAC_BITS);
   localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX  =
      ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN  = -SAT_MAX - ACC_WIDTH'(1);
`ifdef FIR_ROUND_EN
   localparam logic signed [ACC_WIDTH-1:0]  ROUND_K  = ACC_WIDTH'(1) << (FRAC_BITS - 1);
`endif

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      CAP  = 3'd2,
      MAC  = 3'd3,
      OUT  = 3'd4
   } state_t;

   state_t                         state, state_nx;
   logic signed [DATA_WIDTH-1:0]   d_line [TAPS];
   logic signed [COEF_WIDTH-1:0]   coef   [TAPS];
   logic signed [ACC_WIDTH-1:0]    acc, acc_nx, acc_adj, acc_sh;
   logic signed [PROD_W-1:0]       prod;
   logic [TAP_W-1:0]               tap;
   logic                           last_tap;
   logic [DATA_WIDTH-1:0]          sat_val;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   assign last_tap = (tap == TAP_W'(TAPS - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!bus.fifo_empty) state_nx = REQ;
         REQ:     state_nx = CAP;
         CAP:     state_nx = MAC;
         MAC:     if (last_tap) state_nx = OUT;
         OUT:     if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Moore outputs decoded straight from the state register.
   assign bus.fifo_rd_en = (state == REQ);
   assign bus.out_valid  = (state == OUT);
   assign bus.busy       = (state != IDLE);
   assign dbg_state      = state;

   // ---------------- MAC datapath ----------------
   // acc_nx is the accumulator including the current tap; on the last tap
   // it is the full sum, so the output word is formed from it directly and
   // registered on the MAC->OUT transition.
   always_comb begin
      prod   = PROD_W'(d_line[tap]) * PROD_W'(coef[tap]);
      acc_nx = acc + ACC_WIDTH'(prod);
`ifdef FIR_ROUND_EN
      acc_adj = acc_nx + ROUND_K;
`else
      acc_adj = acc_nx;
`endif
      acc_sh = acc_adj >>> FRAC_BITS;
      if (acc_sh > SAT_MAX)      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (acc_sh < SAT_MIN) sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                       sat_val = acc_sh[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < TAPS; k++) begin
            d_line[k] <= '0;
            coef[k]   <= (k == 0) ? COEF_ONE : '0;
         end
         acc          <= '0;
         tap          <= '0;
         bus.out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Writes land even on the cycle that leaves for REQ, so the
               // next sample already sees them.
               if (bus.coef_wr && (32'(bus.coef_addr) < TAPS))
                  coef[bus.coef_addr] <= $signed(bus.coef_data);
            end
            CAP: begin
               for (int k = TAPS - 1; k > 0; k--) d_line[k] <= d_line[k-1];
               d_line[0] <= $signed(bus.fifo_data);
               acc       <= '0;
               tap       <= '0;
            end
            MAC: begin
               acc <= acc_nx;
               tap <= tap + TAP_W'(1);
               if (last_tap) bus.out_data <= sat_val;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_fir_stage.sv
module tb_fifo_fir_stage;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam int FB = 14;
   localparam int TP = 4;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;

   int total     = 0;
   int bad       = 0;
   int rd_cnt    = 0;
   int underflow = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   longint        m_coef [TP];
   longint        m_d    [TP];

   fifo_fir_stage_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TP)) bus();

   fifo_fir_stage #(
      .DATA_WIDTH(DW), .COEF_WIDTH(CW), .FRAC_BITS(FB), .TAPS(TP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- FIFO model (negedge driven) ----------------
   initial begin : fifo_model
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = '0;
      forever begin
         @(negedge clk);
         if (bus.fifo_rd_en === 1'b1) begin
            rd_cnt++;
            if (fifo_q.size() == 0) underflow++;
            else bus.fifo_data = fifo_q.pop_front();
         end
         bus.fifo_empty = (fifo_q.size() == 0);
      end
   end

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int k = 0; k < TP; k++) begin
         m_d[k]    = 0;
         m_coef[k] = (k == 0) ? longint'(1 << FB) : 0;
      end
   endfunction

   function automatic logic [DW-1:0] model_step(input logic [DW-1:0] s);
      longint     sum;
      logic [63:0] r;
      for (int k = TP - 1; k > 0; k--) m_d[k] = m_d[k-1];
      m_d[0] = longint'($signed(s));
      sum = 0;
      for (int k = 0; k < TP; k++) sum += m_d[k] * m_coef[k];
`ifdef FIR_ROUND_EN
      sum += longint'(1) <<< (FB - 1);
`endif
      sum = sum >>> FB;
      if (sum > MAXV)      sum = MAXV;
      else if (sum < MINV) sum = MINV;
      r = sum;
      return r[DW-1:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.coef_wr   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic write_coef(input int addr, input logic [CW-1:0] val);
      @(negedge clk);
      bus.coef_wr   = 1'b1;
      bus.coef_addr = 2'(addr);
      bus.coef_data = val;
      @(negedge clk);
      bus.coef_wr   = 1'b0;
      m_coef[addr]  = longint'($signed(val));
   endtask

   task automatic push(input logic [DW-1:0] s);
      @(posedge clk); #1;
      fifo_q.push_back(s);
      exp_q.push_back(model_step(s));
   endtask

   task automatic wait_accept(input int delay, output logic [DW-1:0] got, output bit ok);
      ok  = 1'b0;
      got = '0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) ok = 1'b1;
      end
      if (ok) begin
         got = bus.out_data;
         repeat (delay) @(negedge clk);
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", bus.fifo_rd_en); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_passthrough();
      logic [DW-1:0] vals [2];
      logic [DW-1:0] got, e;
      bit ok;
      int rd0;
      vals[0] = 32'd5;
      vals[1] = -32'sd3;
      for (int i = 0; i < 2; i++) begin
         rd0 = rd_cnt;
         push(vals[i]);
         wait_accept(0, got, ok);
         e = exp_q.pop_front();
         total++; if (!ok || got !== e) begin bad++; $display("FAIL passthrough[%0d] got=%h ok=%0d want=%h", i, got, ok, e); end
         total++; if (rd_cnt - rd0 != 1) begin bad++; $display("FAIL passthrough_rd[%0d] got=%0d want=1", i, rd_cnt - rd0); end
      end
   endtask

   task automatic test_latency_back_to_back();
      int rd_cyc[$];
      int v_cyc[$];
      logic [DW-1:0] got[$];
      logic [DW-1:0] s, e;
      int r0, r1, v0, v1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         s = $urandom();
         fifo_q.push_back(s);
         exp_q.push_back(model_step(s));
      end
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (bus.fifo_rd_en === 1'b1) rd_cyc.push_back(c);
         if (bus.out_valid === 1'b1) begin
            v_cyc.push_back(c);
            got.push_back(bus.out_data);
         end
      end
      bus.out_ready = 1'b0;
      r0 = (rd_cyc.size() > 0) ? rd_cyc[0] : -1;
      r1 = (rd_cyc.size() > 1) ? rd_cyc[1] : -1;
      v0 = (v_cyc.size() > 0) ? v_cyc[0] : -1;
      v1 = (v_cyc.size() > 1) ? v_cyc[1] : -1;
      total++; if (rd_cyc.size() != 2 || r0 != 1 || r1 != 9) begin bad++; $display("FAIL latency_rd n=%0d first=%0d second=%0d want n=2 1 9", rd_cyc.size(), r0, r1); end
      total++; if (v_cyc.size() != 2 || v0 != 7 || v1 != 15) begin bad++; $display("FAIL latency_valid n=%0d first=%0d second=%0d want n=2 7 15", v_cyc.size(), v0, v1); end
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         total++; if (i >= got.size() || got[i] !== e) begin bad++; $display("FAIL latency_data[%0d] want=%h n=%0d", i, e, got.size()); end
      end
   endtask

   task automatic test_moving_sum();
      logic [DW-1:0] got, e;
      bit ok;
      apply_reset();
      for (int k = 0; k < TP; k++) write_coef(k, 16'd16384);
      for (int i = 1; i <= 4; i++) begin
         push(32'(i));
         wait_accept(0, got, ok);
         e = exp_q.pop_front();
         total++; if (!ok || got !== e) begin bad++; $display("FAIL moving_sum[%0d] got=%h ok=%0d want=%h", i, got, ok, e); end
      end
   endtask

   task automatic test_saturation();
      logic [DW-1:0] got, e;
      bit ok;
      for (int i = 0; i < 8; i++) begin
         push((i < 4) ? 32'h7FFF_FFFF : 32'h8000_0000);
         wait_accept(1, got, ok);
         e = exp_q.pop_front();
         total++; if (!ok || got !== e) begin bad++; $display("FAIL saturation[%0d] got=%h ok=%0d want=%h", i, got, ok, e); end
      end
   endtask

   task automatic test_rounding();
      logic [DW-1:0] got, e;
      logic [DW-1:0] spec_v [2];
      bit ok;
`ifdef FIR_ROUND_EN
      spec_v[0] = 32'd2;
      spec_v[1] = -32'sd1;
`else
      spec_v[0] = 32'd1;
      spec_v[1] = -32'sd2;
`endif
      apply_reset();
      write_coef(0, 16'd8192);
      for (int i = 0; i < 2; i++) begin
         push((i == 0) ? 32'd3 : -32'sd3);
         wait_accept(0, got, ok);
         e = exp_q.pop_front();
         total++; if (!ok || got !== e || got !== spec_v[i]) begin bad++; $display("FAIL rounding[%0d] got=%h ok=%0d want=%h", i, got, ok, spec_v[i]); end
      end
   endtask

   task automatic test_back_pressure();
      logic [DW-1:0] got, got2, e;
      bit ok, stable;
      int rd0;
      push(32'd1000);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) ok = 1'b1;
      end
      got = bus.out_data;
      push(32'd2222);
      rd0 = rd_cnt;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 2) begin
            bus.coef_wr   = 1'b1;
            bus.coef_addr = 2'd0;
            bus.coef_data = 16'h4000;
         end
         if (i == 3) bus.coef_wr = 1'b0;
         if (bus.out_valid !== 1'b1 || bus.out_data !== got) stable = 1'b0;
      end
      total++; if (!ok || !stable) begin bad++; $display("FAIL bp_stable ok=%0d stable=%0d want 1 1", ok, stable); end
      total++; if (rd_cnt != rd0) begin bad++; $display("FAIL bp_no_rd got=%0d want=0", rd_cnt - rd0); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      e = exp_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL bp_data got=%h want=%h", got, e); end
      wait_accept(0, got2, ok);
      e = exp_q.pop_front();
      total++; if (!ok || got2 !== e) begin bad++; $display("FAIL bp_coef_ignored got=%h ok=%0d want=%h", got2, ok, e); end
   endtask

   task automatic test_random();
      logic [DW-1:0] got, e, s;
      bit ok;
      apply_reset();
      for (int k = 0; k < TP; k++) write_coef(k, 16'($urandom_range(0, 65535)));
      for (int i = 0; i < 16; i++) begin
         s = $urandom();
         if ($urandom_range(0, 1) == 1) s = 32'($signed($urandom_range(0, 2000)) - 1000);
         push(s);
         wait_accept($urandom_range(0, 3), got, ok);
         e = exp_q.pop_front();
         total++; if (!ok || got !== e) begin bad++; $display("FAIL random[%0d] in=%h got=%h ok=%0d want=%h", i, s, got, ok, e); end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] got, e;
      bit ok, seen;
      @(posedge clk); #1;
      fifo_q.push_back(32'd100);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.fifo_rd_en === 1'b1) seen = 1'b1;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (!seen || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_ctrl seen=%0d valid=%b busy=%b want 1 0 0", seen, bus.out_valid, bus.busy); end
      total++; if (bus.out_data !== '0 || bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL midrst_out data=%h rd=%b want 0 0", bus.out_data, bus.fifo_rd_en); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      push(32'd7);
      wait_accept(0, got, ok);
      e = exp_q.pop_front();
      total++; if (!ok || got !== e || got !== 32'd7) begin bad++; $display("FAIL midrst_passthrough got=%h ok=%0d want=%h", got, ok, e); end
      total++; if (underflow != 0 || exp_q.size() != 0) begin bad++; $display("FAIL underflow_or_leftover underflow=%0d left=%0d want 0 0", underflow, exp_q.size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst           = 1'b0;
      bus.coef_wr   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.out_ready = 1'b0;
      model_reset();
      test_reset();
      test_passthrough();
      test_latency_back_to_back();
      test_moving_sum();
      test_saturation();
      test_rounding();
      test_back_pressure();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
